cmul_rr_arbiter: RTL and testbench

- Shares one complex-multiplier core (start/ready handshake, operands X, Y, results RR, IR) between NREQ requesters.
- Picks a requester round-robin and registers its operands into the core inputs. Drives the core start handshake, waits for the core to finish, captures the result and returns a one-cycle done pulse to the winner.
- Sits between the processing channels and the single shared multiplier instance.

---
 rtl/cmul_rr_arbiter.sv | 118 +++++++++++
 tb/tb_cmul_rr_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmul_rr_arbiter.sv
// Round-robin arbiter sharing one complex-multiplier core between NREQ requesters.
// Registers the winner's operands, runs the core handshake and returns a one-cycle done pulse.
module cmul_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 16,
  parameter int RW   = 33
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*2*DW-1:0]   op_x,
  input  logic [NREQ*2*DW-1:0]   op_y,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic [RW-1:0]          res_re,
  output logic [RW-1:0]          res_im,
  output logic                   busy,
  output logic [15:0]            txn_cnt,
  output logic                   core_start,
  output logic [DW-1:0]          core_xr,
  output logic [DW-1:0]          core_xi,
  output logic [DW-1:0]          core_yr,
  output logic [DW-1:0]          core_yi,
  input  logic                   core_ready,
  input  logic [RW-1:0]          core_rr,
  input  logic [RW-1:0]          core_ir
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [2:0] {IDLE, START, WAITLO, WAITHI, DONE} state_t;

  state_t          state, stateNext;
  logic [IW-1:0]   last, idx, winner, cand;
  logic            found;
  logic [NREQ-1:0] idxOh;
  logic [2*DW-1:0] xArr [NREQ];
  logic [2*DW-1:0] yArr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : gUnpack
    assign xArr[i] = op_x[i*2*DW +: 2*DW];
    assign yArr[i] = op_y[i*2*DW +: 2*DW];
  end

  // Search starts just after the last winner, so the previous owner has lowest priority.
  always_comb begin
    // NOTE: every variable gets a value before any branch, so no latch is inferred.
    winner = last;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last) + k) % NREQ);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (found && core_ready) stateNext = START;
      START:   stateNext = WAITLO;
      WAITLO:  if (!core_ready) stateNext = WAITHI;
      WAITHI:  if (core_ready) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state <= stateNext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last    <= IW'(NREQ - 1);
      idx     <= '0;
      core_xr <= '0;
      core_xi <= '0;
      core_yr <= '0;
      core_yi <= '0;
      res_re  <= '0;
      res_im  <= '0;
      txn_cnt <= '0;
    end else begin
      if (state == IDLE && stateNext == START) begin
        idx     <= winner;
        core_xr <= xArr[winner][2*DW-1:DW];
        core_xi <= xArr[winner][DW-1:0];
        core_yr <= yArr[winner][2*DW-1:DW];
        core_yi <= yArr[winner][DW-1:0];
      end
      if (state == WAITHI && core_ready) begin
        res_re <= core_rr;
        res_im <= core_ir;
      end
      if (state == DONE) begin
        last    <= idx;
        txn_cnt <= txn_cnt + 16'd1;
      end
    end
  end

  // All outputs decode registered state, so they are glitch-free and zero in reset.
  assign idxOh      = NREQ'(1) << idx;
  assign busy       = (state != IDLE);
  assign core_start = (state == START);
  assign gnt        = busy ? idxOh : '0;
  assign done       = (state == DONE) ? idxOh : '0;

endmodule

// File: tb/tb_cmul_rr_arbiter.sv
// Bench for cmul_rr_arbiter: transaction-level model checked every cycle, plus directed
// scenarios with hand-computed expectations and a latency-20 complex-multiplier core model.
module tb_cmul_rr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int RW   = 33;
  localparam int CORE_LAT = 20;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*2*DW-1:0]  op_x = '0;
  logic [NREQ*2*DW-1:0]  op_y = '0;
  logic [NREQ-1:0]       gnt, done;
  logic [RW-1:0]         res_re, res_im, core_rr, core_ir;
  logic                  busy, core_start, core_ready;
  logic [15:0]           txn_cnt;
  logic [DW-1:0]         core_xr, core_xi, core_yr, core_yi;

  int nTests = 0;
  int nFail  = 0;

  cmul_rr_arbiter #(.NREQ(NREQ), .DW(DW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .req(req), .op_x(op_x), .op_y(op_y),
    .gnt(gnt), .done(done), .res_re(res_re), .res_im(res_im), .busy(busy),
    .txn_cnt(txn_cnt), .core_start(core_start),
    .core_xr(core_xr), .core_xi(core_xi), .core_yr(core_yr), .core_yi(core_yi),
    .core_ready(core_ready), .core_rr(core_rr), .core_ir(core_ir)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Core model: drops ready the cycle after start falls, rises CORE_LAT cycles later.
  logic coreRdy, seenStart, coreHold = 1'b0;
  int   coreCnt;
  assign core_ready = coreRdy & ~coreHold;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      coreRdy <= 1'b1; seenStart <= 1'b0; coreCnt <= 0; core_rr <= '0; core_ir <= '0;
    end else begin
      seenStart <= core_start;
      if (seenStart && !core_start) begin
        coreRdy <= 1'b0;
        coreCnt <= CORE_LAT;
      end else if (coreCnt > 0) begin
        coreCnt <= coreCnt - 1;
        if (coreCnt == 1) begin
          coreRdy <= 1'b1;
          core_rr <= RW'(longint'($signed(core_xr)) * $signed(core_yr) - longint'($signed(core_xi)) * $signed(core_yi));
          core_ir <= RW'(longint'($signed(core_xr)) * $signed(core_yi) + longint'($signed(core_xi)) * $signed(core_yr));
        end
      end
    end
  end

  // Transaction-level model: owner, handshake progress, pointer, counter, expected product.
  int              mOwner, mLast;
  bit              mStart, mSawLow, mDone;
  logic [15:0]     mCnt;
  logic [DW-1:0]   mXr, mXi, mYr, mYi;
  logic [RW-1:0]   mRe, mIm;

  task automatic modelReset();
    mOwner = -1; mLast = NREQ - 1; mStart = 0; mSawLow = 0; mDone = 0; mCnt = '0;
    mXr = '0; mXi = '0; mYr = '0; mYi = '0; mRe = '0; mIm = '0;
  endtask

  task automatic modelStep();
    if (mDone) begin
      mDone = 0; mLast = mOwner; mOwner = -1; mCnt = mCnt + 16'd1;
    end else if (mOwner < 0) begin
      if (core_ready && req != '0) begin
        for (int k = 1; k <= NREQ; k++) begin
          int c;
          c = (mLast + k) % NREQ;
          if (req[c]) begin mOwner = c; break; end
        end
        mXr = op_x[mOwner*2*DW+DW +: DW]; mXi = op_x[mOwner*2*DW +: DW];
        mYr = op_y[mOwner*2*DW+DW +: DW]; mYi = op_y[mOwner*2*DW +: DW];
        mStart = 1; mSawLow = 0;
      end
    end else if (mStart) begin
      mStart = 0;
    end else if (!mSawLow) begin
      mSawLow = !core_ready;
    end else if (core_ready) begin
      mRe = RW'(longint'($signed(mXr)) * $signed(mYr) - longint'($signed(mXi)) * $signed(mYi));
      mIm = RW'(longint'($signed(mXr)) * $signed(mYi) + longint'($signed(mXi)) * $signed(mYr));
      mDone = 1;
    end
  endtask

  always @(posedge clk) begin
    logic [NREQ-1:0] expG;
    if (rst) modelReset(); else modelStep();
    #1;
    expG = (mOwner >= 0) ? (NREQ'(1) << mOwner) : '0;
    check("gnt", gnt, expG);
    check("done", done, mDone ? expG : '0);
    check("core_start", core_start, mStart);
    check("busy", busy, mOwner >= 0);
    check("txn_cnt", txn_cnt, mCnt);
    check("res_re", res_re, mRe);
    check("res_im", res_im, mIm);
    check("core_ops", {core_xr, core_xi, core_yr, core_yi}, {mXr, mXi, mYr, mYi});
  end

  task automatic setOps(input int i, input int xr, input int xi, input int yr, input int yi);
    op_x[i*2*DW +: 2*DW] = {DW'(xr), DW'(xi)};
    op_y[i*2*DW +: 2*DW] = {DW'(yr), DW'(yi)};
  endtask

  task automatic waitDone(input string name, input logic [NREQ-1:0] expDone);
    int n;
    n = 0;
    while (done === '0 && n < 60) begin @(negedge clk); n++; end
    if (done === '0) begin
      nTests++; nFail++;
      $display("FAIL %s: no done within 60 cycles, expected %0h", name, expDone);
    end else begin
      check(name, done, expDone);
    end
  endtask

  task automatic pulseReset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_gnt", gnt, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_cnt", txn_cnt, 16'd0);
    check("rst_res", {res_re, res_im}, '0);
    rst = 1'b0;
    @(negedge clk);

    // Single request: (3+4j)(1+2j) = -5+10j
    setOps(1, 3, 4, 1, 2);
    req = 4'b0010;
    @(negedge clk);
    check("t1_start", core_start, 1'b1);
    check("t1_gnt", gnt, 4'b0010);
    waitDone("t1_done", 4'b0010);
    check("t1_re", res_re, 33'h1_FFFF_FFFB);
    check("t1_im", res_im, 33'd10);
    req = '0;
    @(negedge clk);
    check("t1_pulse", done, 4'b0000);
    check("t1_cnt", txn_cnt, 16'd1);

    // Simultaneous 0101 after reset: 0 then 2
    pulseReset();
    setOps(0, 1, 1, 1, 1); setOps(2, 2, -1, 5, 7);
    req = 4'b0101;
    waitDone("t2_first", 4'b0001);
    req[0] = 1'b0;
    @(negedge clk);
    waitDone("t2_second", 4'b0100);
    check("t2_re", res_re, 33'd17);
    check("t2_im", res_im, 33'd9);

    // All four held after requester 2: 3,0,1,2
    req = 4'b1111;
    setOps(3, -9, 4, 6, -2);
    @(negedge clk);
    waitDone("t3_a", 4'b1000); @(negedge clk);
    waitDone("t3_b", 4'b0001); @(negedge clk);
    waitDone("t3_c", 4'b0010); @(negedge clk);
    waitDone("t3_d", 4'b0100);
    req = '0;
    @(negedge clk);
    check("t3_cnt", txn_cnt, 16'd6);

    // Operand stability: (-7+5j)(2-3j) = 1+31j despite op_x change while busy
    setOps(2, -7, 5, 2, -3);
    req = 4'b0100;
    repeat (6) @(negedge clk);
    setOps(2, 1000, -1000, 2, -3);
    check("t4_xr", core_xr, 16'hFFF9);
    check("t4_xi", core_xi, 16'h0005);
    waitDone("t4_done", 4'b0100);
    check("t4_re", res_re, 33'd1);
    check("t4_im", res_im, 33'd31);
    req = '0;
    @(negedge clk);

    // core_ready held low blocks arbitration; boundary operands
    coreHold = 1'b1;
    setOps(0, -32768, -32768, -32768, 32767);
    req = 4'b0001;
    repeat (5) @(negedge clk);
    check("t5_nogrant", gnt, 4'b0000);
    coreHold = 1'b0;
    @(negedge clk);
    check("t5_grant", gnt, 4'b0001);
    waitDone("t5_done", 4'b0001);
    check("t5_re", res_re, 33'h0_7FFF_8000);
    check("t5_im", res_im, 33'h0_0000_8000);
    req = '0;
    @(negedge clk);

    // Reset during WAITHI, then serve req[0] normally
    setOps(0, 3, 4, 1, 2);
    req = 4'b0001;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_gnt", gnt, 4'b0000);
    check("t6_busy", busy, 1'b0);
    check("t6_start", core_start, 1'b0);
    check("t6_res", {res_re, res_im}, '0);
    check("t6_cnt", txn_cnt, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    waitDone("t6_done", 4'b0001);
    check("t6_re", res_re, 33'h1_FFFF_FFFB);
    req = '0;
    @(negedge clk);
    check("t6_cnt1", txn_cnt, 16'd1);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
